// File: rtl/ic74165_piso_tx.sv
// Cascaded 74LS165 PISO transmitter with internal load/shift sequencer and serial clock.
// Optional odd-parity trailer bit enabled by defining IC74165_PISO_TX_PARITY_EN.
module ic74165_piso_tx #(
  parameter int CHIPS   = 1,
  parameter int DIVIDER = 4
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               start,
  input  logic [8*CHIPS-1:0] data_in,
  input  logic               ser,
  output logic               q,
  output logic               q_n,
  output logic               sclk,
  output logic               busy,
  output logic               done
);

  localparam int N  = 8 * CHIPS;
  localparam int BW = $clog2(N + 1);
  localparam int DW = $clog2(DIVIDER + 1);
  localparam logic [DW-1:0] DIV_LAST = DW'(DIVIDER - 1);
`ifdef IC74165_PISO_TX_PARITY_EN
  localparam logic [BW-1:0] DATA_LAST = BW'(N - 1);
  localparam logic [BW-1:0] BIT_LAST  = BW'(N);
`else
  localparam logic [BW-1:0] BIT_LAST  = BW'(N - 1);
`endif

  typedef enum logic [1:0] {IDLE, SHIFT_LOW, SHIFT_HIGH, DONE} state_t;

  state_t          state_q, state_d;
  logic [N-1:0]    sr_q, sr_d;
  logic [BW-1:0]   bit_q, bit_d;
  logic [DW-1:0]   div_q, div_d;
`ifdef IC74165_PISO_TX_PARITY_EN
  logic            par_q, par_d;
  logic            par_sel_q, par_sel_d;
`endif

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q   <= IDLE;
      sr_q      <= '0;
      bit_q     <= '0;
      div_q     <= '0;
`ifdef IC74165_PISO_TX_PARITY_EN
      par_q     <= 1'b0;
      par_sel_q <= 1'b0;
`endif
    end else begin
      state_q   <= state_d;
      sr_q      <= sr_d;
      bit_q     <= bit_d;
      div_q     <= div_d;
`ifdef IC74165_PISO_TX_PARITY_EN
      par_q     <= par_d;
      par_sel_q <= par_sel_d;
`endif
    end
  end

  always_comb begin
    state_d   = state_q;
    sr_d      = sr_q;
    bit_d     = bit_q;
    div_d     = div_q;
`ifdef IC74165_PISO_TX_PARITY_EN
    par_d     = par_q;
    par_sel_d = par_sel_q;
`endif
    case (state_q)
      IDLE: begin
        if (start) begin
          sr_d    = data_in;
          bit_d   = '0;
          div_d   = '0;
          state_d = SHIFT_LOW;
`ifdef IC74165_PISO_TX_PARITY_EN
          par_d     = ~^data_in;
          par_sel_d = 1'b0;
`endif
        end
      end
      SHIFT_LOW: begin
        if (div_q == DIV_LAST) begin
          div_d   = '0;
          state_d = SHIFT_HIGH;
        end else begin
          div_d = div_q + 1'b1;
        end
      end
      SHIFT_HIGH: begin
        if (div_q == DIV_LAST) begin
          div_d = '0;
          if (bit_q == BIT_LAST) begin
            state_d = DONE;
          end else begin
            bit_d   = bit_q + 1'b1;
            state_d = SHIFT_LOW;
`ifdef IC74165_PISO_TX_PARITY_EN
            // After the last data bit q switches to the latched parity instead of shifting.
            if (bit_q == DATA_LAST) par_sel_d = 1'b1;
            else                    sr_d      = {sr_q[N-2:0], ser};
`else
            sr_d = {sr_q[N-2:0], ser};
`endif
          end
        end else begin
          div_d = div_q + 1'b1;
        end
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
`ifdef IC74165_PISO_TX_PARITY_EN
    q = par_sel_q ? par_q : sr_q[N-1];
`else
    q = sr_q[N-1];
`endif
    q_n  = ~q;
    sclk = (state_q == SHIFT_HIGH);
    busy = (state_q == SHIFT_LOW) || (state_q == SHIFT_HIGH);
    done = (state_q == DONE);
  end

endmodule

// File: doc/ic74165_piso_tx.md
Name: ic74165_piso_tx

Overview:
- Synthesizable transmitter model of a chain of 74LS165 parallel-in/serial-out shift registers, driven by an internal load/shift sequencer.
- Feeds the serial side of the glue logic, e.g. joystick/keyboard-style serial links into a 74164-style receiver.
- Latches a parallel word on request and shifts it out MSB first (Q7 of the first chip first), producing its own serial clock.
- Reports progress with a busy level and a one-cycle done pulse.

Parameters:
- CHIPS, 1: number of cascaded 8-bit stages. Word width N = 8*CHIPS.
- DIVIDER, 4: system clocks per serial-clock half period. Must be >= 1.

Ports:
- clk  input  1  system clock; all state changes on its rising edge.
- reset  input  1  asynchronous, active-high reset.
- start  input  1  request a transfer; sampled only in IDLE.
- data_in  input  N  parallel word, latched on the edge that accepts start.
- ser  input  1  cascade serial input (74165 SER); shifted into the LSB on each shift.
- q  output  1  serial data out (Q7 of the last stage).
- q_n  output  1  always the complement of q.
- sclk  output  1  serial clock; the receiver samples q on its rising edge.
- busy  output  1  high while a frame is in progress.
- done  output  1  one-cycle pulse at the end of a frame.

Behaviour:
- Reset, asynchronous, any state including mid-frame:
  - state goes to IDLE; shift register, bit counter and divider counter clear to 0.
  - q=0, q_n=1, sclk=0, busy=0, done=0.
  - The aborted frame is not resumed.
- States: IDLE, SHIFT_LOW, SHIFT_HIGH, DONE.
- IDLE:
  - sclk=0, busy=0, q holds its last value.
  - On a rising edge with start=1: load data_in into the shift register, clear counters, set busy=1, go to SHIFT_LOW.
  - q shows data_in[N-1] from that edge onward.
- SHIFT_LOW: sclk=0 for DIVIDER cycles, then sclk goes to 1 and the state moves to SHIFT_HIGH.
- SHIFT_HIGH: sclk=1 for DIVIDER cycles, then sclk goes to 0 and:
  - If the bit counter equals N-1: go to DONE; the shift register is not shifted.
  - Otherwise: shift the register left by one (ser enters bit 0), increment the bit counter, return to SHIFT_LOW.
- q only changes on sclk falling edges (or at load), so it is stable for DIVIDER cycles on either side of every sclk rising edge.
- DONE:
  - Lasts exactly one cycle: done=1, busy=0, sclk=0, q holds the last bit.
  - Always returns to IDLE.
- Timing:
  - done is high in the cycle after the edge that falls 2*DIVIDER*N cycles after the edge that accepted start.
  - With start held continuously high, the next frame is accepted one cycle after done (the IDLE cycle).
- start while busy, or during DONE, is ignored; it is not queued.
- data_in changes after the load edge do not affect the frame.
- Counter widths: bit counter $clog2(N+1) bits; divider counter $clog2(DIVIDER+1) bits. No wrap occurs within a legal frame.

Optional Feature:
- Macro: IC74165_PISO_TX_PARITY_EN.
- Defined:
  - At load, an odd-parity bit P = ~^data_in is latched.
  - After the N data bits, one extra sclk period sends P on q.
  - Frame length is N+1 bits; done comes 2*DIVIDER*(N+1) cycles after the accepting edge.
  - ser is ignored during the parity bit.
- Undefined: frame is exactly N bits and there is no parity logic.

Test Plan:
- Reset: CHIPS=1, DIVIDER=2, reset=1 -> q=0, q_n=1, sclk=0, busy=0, done=0 immediately, without waiting for a clk edge.
- Basic frame: data_in=8'hA5, start pulse -> q sampled on sclk rising edges reads 1,0,1,0,0,1,0,1; exactly 8 sclk rising edges; busy high throughout; done is a single cycle at 32 cycles after the accepting edge.
- Start while busy: data_in=8'h3C, then a second start with 8'hFF during the frame -> output is still 3C's bits; no second frame; one done pulse only.
- Reset mid-frame: assert reset after the 3rd sclk rise of 8'hF0 -> all outputs return to reset values at once; a fresh start with 8'h0F produces the full 0,0,0,0,1,1,1,1.
- Cascade/back-to-back: CHIPS=2, DIVIDER=1, data_in=16'h8001, start held high -> 1, fourteen 0s, 1 per frame; the second frame is accepted the cycle after done; q_n == ~q throughout.
- Parity (macro on): CHIPS=1, data_in=8'hA5 -> 9th bit = 1; data_in=8'hA4 -> 9th bit = 0; done at 36 cycles with DIVIDER=2.
